intt_result_collector: RTL

//  Receives the parallel result stream of the INTT processor (one row of 2*2^LOG_CORE_COUNT
//  60-bit lane words per cycle, qualified by the processor's output_active and address_out)

---
 rtl/intt_result_collector_if.sv | 26 ++
 rtl/intt_result_collector.sv | 103 ++++++++++
 2 files changed

// File: rtl/intt_result_collector_if.sv
// Row-in / coefficient-out bus between intt_processor, the result collector and the host side.
interface intt_result_collector_if #(
  parameter int LOG_CORE_COUNT = 4
);
  localparam int C = 1 << LOG_CORE_COUNT;

  logic                    in_active;
  logic [8:0]              in_address;
  logic [C-1:0][1:0][59:0] in_data;
  logic [29:0]             m_data;
  logic                    m_valid;
  logic                    m_ready;
  logic                    m_last;
  logic                    idle;
  logic                    err;

  modport master (
    output in_active, in_address, in_data, m_ready,
    input  m_data, m_valid, m_last, idle, err
  );

  modport slave (
    input  in_active, in_address, in_data, m_ready,
    output m_data, m_valid, m_last, idle, err
  );
endinterface

// File: rtl/intt_result_collector.sv
// Buffers one polynomial of INTT result rows, then drains the coefficients in natural index
// order over a valid/ready stream.
module intt_result_collector #(
  parameter int LOG_CORE_COUNT = 4,
  parameter int LOG_N          = 12
) (
  input logic                    clk,
  input logic                    rst,
  intt_result_collector_if.slave bus
);
  // state | meaning
  // IDLE  | empty, waiting for the first row
  // FILL  | collecting rows until all ROWS have been written
  // DRAIN | streaming coefficients 0..N-1 to the sink
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam int C        = 1 << LOG_CORE_COUNT;
  localparam int COL_W    = LOG_CORE_COUNT + 2;
  localparam int ROW_W    = LOG_N - COL_W;
  localparam int ROWS     = 1 << ROW_W;
  localparam int ROW_BITS = 4 * C * 30;

  localparam logic [8:0]     ROWS_ADDR = 9'(ROWS);
  localparam logic [ROW_W:0] ROWS_CNT  = (ROW_W + 1)'(ROWS);

  // A packed row lands with coefficient k*4+j*2+h at bit offset (k*4+j*2+h)*30,
  // so a row word is already in natural coefficient order.
  logic [ROW_BITS-1:0] mem [ROWS];

  logic [1:0]       state;
  logic [ROW_W:0]   row_cnt;
  logic [LOG_N-1:0] rd_idx;
  logic             primed;

  logic             addr_ok;
  logic             row_wr;
  logic             hs;
  logic             load_out;
  logic [ROW_W:0]   cnt_next;
  logic [COL_W-1:0] rd_col;
  logic [ROW_W-1:0] rd_row;

  assign addr_ok  = bus.in_address < ROWS_ADDR;
  assign row_wr   = bus.in_active && addr_ok && (state != S_DRAIN);
  assign cnt_next = row_cnt + 1'b1;
  assign hs       = bus.m_valid && bus.m_ready;
  assign rd_col   = rd_idx[COL_W-1:0];
  assign rd_row   = rd_idx[LOG_N-1:COL_W];
  // primed delays the first load one cycle after entering DRAIN; m_last blocks loads past N-1
  assign load_out = (state == S_DRAIN) && primed &&
                    (!bus.m_valid || (bus.m_ready && !bus.m_last));
  assign bus.idle = (state == S_IDLE);

  always_ff @(posedge clk) begin
    if (row_wr) begin
      mem[bus.in_address[ROW_W-1:0]] <= bus.in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      row_cnt     <= '0;
      rd_idx      <= '0;
      primed      <= 1'b0;
      bus.m_valid <= 1'b0;
      bus.m_last  <= 1'b0;
      bus.m_data  <= '0;
      bus.err     <= 1'b0;
    end else begin
      if (bus.in_active && (!addr_ok || state == S_DRAIN)) begin
        bus.err <= 1'b1;
      end
      case (state)
        S_IDLE, S_FILL: begin
          if (row_wr) begin
            row_cnt <= cnt_next;
            state   <= (cnt_next == ROWS_CNT) ? S_DRAIN : S_FILL;
          end
        end
        S_DRAIN: begin
          primed <= 1'b1;
          if (hs && bus.m_last) begin
            state       <= S_IDLE;
            row_cnt     <= '0;
            rd_idx      <= '0;
            primed      <= 1'b0;
            bus.m_valid <= 1'b0;
            bus.m_last  <= 1'b0;
          end else if (load_out) begin
            bus.m_data  <= mem[rd_row][int'(rd_col) * 30 +: 30];
            bus.m_valid <= 1'b1;
            bus.m_last  <= (rd_idx == '1);
            rd_idx      <= rd_idx + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
